// File: rtl/time_set_controller_if.sv
// Button and display bundle between the debouncers, the mode sequencer and the clock/alarm FSMs.
// The slave side is the sequencer itself; the master side drives the button pulses.
interface time_set_controller_if;
  logic       sec_tick_pi;
  logic       mode_btn_pi;
  logic       inc_min_btn_pi;
  logic       inc_hour_btn_pi;
  logic [1:0] mode_po;
  logic [1:0] disp_sel_po;
  logic       blink_en_po;
  logic       clock_hold_po;
  logic       sec_clear_po;
  logic       clk_inc_min_po;
  logic       clk_inc_hour_po;
  logic       al0_inc_min_po;
  logic       al0_inc_hour_po;
  logic       al1_inc_min_po;
  logic       al1_inc_hour_po;

  modport slave (
    input  sec_tick_pi, mode_btn_pi, inc_min_btn_pi, inc_hour_btn_pi,
    output mode_po, disp_sel_po, blink_en_po, clock_hold_po, sec_clear_po,
           clk_inc_min_po, clk_inc_hour_po, al0_inc_min_po, al0_inc_hour_po,
           al1_inc_min_po, al1_inc_hour_po
  );

  modport master (
    output sec_tick_pi, mode_btn_pi, inc_min_btn_pi, inc_hour_btn_pi,
    input  mode_po, disp_sel_po, blink_en_po, clock_hold_po, sec_clear_po,
           clk_inc_min_po, clk_inc_hour_po, al0_inc_min_po, al0_inc_hour_po,
           al1_inc_min_po, al1_inc_hour_po
  );
endinterface

// File: rtl/time_set_controller.sv
// Alarm-clock mode sequencer: RUN / SET_CLOCK / SET_ALARM0 / SET_ALARM1, button steering,
// display select, blink and an idle-seconds timeout back to RUN.
module time_set_controller #(
  parameter int unsigned TIMEOUT_S = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                  clk_pi,
  input  logic                  rst_pi,
  time_set_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SET_CLOCK  = 2'd1,
    SET_ALARM0 = 2'd2,
    SET_ALARM1 = 2'd3
  } mode_t;

  // Count value at which the next second tick expires the SET mode.
  localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT_S == 0) ? '0 : CNT_W'(TIMEOUT_S - 1);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             sec_clear_q, sec_clear_d;
  logic [5:0]       inc_q, inc_d;   // {clk_min, clk_hour, al0_min, al0_hour, al1_min, al1_hour}
  logic             any_inc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      mode_q      <= RUN;
      idle_q      <= '0;
      sec_clear_q <= 1'b0;
      inc_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      idle_q      <= idle_d;
      sec_clear_q <= sec_clear_d;
      inc_q       <= inc_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    mode_d  = mode_q;
    idle_d  = idle_q;
    inc_d   = '0;
    any_inc = bus.inc_min_btn_pi | bus.inc_hour_btn_pi;

    if (bus.mode_btn_pi) begin
      // Mode button wins over any coincident inc or tick.
      unique case (mode_q)
        RUN:        mode_d = SET_CLOCK;
        SET_CLOCK:  mode_d = SET_ALARM0;
        SET_ALARM0: mode_d = SET_ALARM1;
        SET_ALARM1: mode_d = RUN;
      endcase
      idle_d = '0;
    end else if (mode_q == RUN) begin
      idle_d = '0;
    end else if (any_inc) begin
      idle_d = '0;
      unique case (mode_q)
        SET_CLOCK:  inc_d[5:4] = {bus.inc_min_btn_pi, bus.inc_hour_btn_pi};
        SET_ALARM0: inc_d[3:2] = {bus.inc_min_btn_pi, bus.inc_hour_btn_pi};
        SET_ALARM1: inc_d[1:0] = {bus.inc_min_btn_pi, bus.inc_hour_btn_pi};
        default:    ;
      endcase
    end else if (bus.sec_tick_pi && (TIMEOUT_S != 0)) begin
      if (idle_q == LAST_CNT) begin
        mode_d = RUN;
        idle_d = '0;
      end else if (idle_q != '1) begin
        idle_d = idle_q + CNT_W'(1);
      end
    end

    // Pulse lands in the first cycle the mode register has left SET_CLOCK.
    sec_clear_d = (mode_q == SET_CLOCK) && (mode_d != SET_CLOCK);
  end

  always_comb begin
    unique case (mode_q)
      SET_ALARM0: bus.disp_sel_po = 2'd1;
      SET_ALARM1: bus.disp_sel_po = 2'd2;
      default:    bus.disp_sel_po = 2'd0;
    endcase
  end

  assign bus.mode_po         = mode_q;
  assign bus.blink_en_po     = (mode_q != RUN);
  assign bus.clock_hold_po   = (mode_q == SET_CLOCK);
  assign bus.sec_clear_po    = sec_clear_q;
  assign bus.clk_inc_min_po  = inc_q[5];
  assign bus.clk_inc_hour_po = inc_q[4];
  assign bus.al0_inc_min_po  = inc_q[3];
  assign bus.al0_inc_hour_po = inc_q[2];
  assign bus.al1_inc_min_po  = inc_q[1];
  assign bus.al1_inc_hour_po = inc_q[0];

endmodule
